fifo_rd_sched: RTL and testbench

- Round-robin read scheduler that shares the read port of the async FIFO among NUM_REQ consumers in the read clock domain.
- Sits between the FIFO read-pointer/empty logic and the consumers.
- Drives the FIFO pop strobe and grants bursts of up to MAX_BURST entries to one consumer at a time.
- Delivers each popped word through a registered output stage, tagged with a one-hot consumer valid.

---
 rtl/fifo_rd_sched_if.sv | 25 ++
 rtl/fifo_rd_sched.sv | 93 +++++++++
 tb/tb_fifo_rd_sched.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_sched_if.sv
// rtl/fifo_rd_sched_if.sv - consumer, FIFO-read and output signals of the read scheduler
interface fifo_rd_sched_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    rdy;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_rinc;
  logic [NUM_REQ-1:0]    gnt;
  logic [DATA_WIDTH-1:0] dout;
  logic [NUM_REQ-1:0]    dout_vld;
  logic                  busy;

  modport master (
    input  req, rdy, fifo_empty, fifo_rdata,
    output fifo_rinc, gnt, dout, dout_vld, busy
  );

  modport slave (
    output req, rdy, fifo_empty, fifo_rdata,
    input  fifo_rinc, gnt, dout, dout_vld, busy
  );
endinterface

// File: rtl/fifo_rd_sched.sv
// rtl/fifo_rd_sched.sv - round-robin burst scheduler sharing one FIFO read port
module fifo_rd_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                rclk,
  input  logic                rst,
  fifo_rd_sched_if.master     bus
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SERVE = 1'b1;

  logic [0:0]            state;
  logic [OW-1:0]         owner;
  logic [OW-1:0]         last;
  logic [CW-1:0]         cnt;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [NUM_REQ-1:0]    vld_q;

  logic [OW-1:0]         win;
  logic [OW-1:0]         idx;
  logic                  found;
  logic                  pop;
  logic                  last_pop;

  // Search starts just after the previous winner, so the last owner ranks lowest.
  always_comb begin
    win   = last;
    idx   = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = OW'((int'(last) + i) % NUM_REQ);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Reset gates the strobe so no word is consumed in the reset cycle.
  assign pop = (state == SERVE) && !rst && !bus.fifo_empty &&
               bus.req[owner] && bus.rdy[owner];
  assign last_pop = pop && (cnt == CW'(MAX_BURST - 1));

  always_ff @(posedge rclk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      last   <= OW'(NUM_REQ - 1);
      cnt    <= '0;
      gnt_q  <= '0;
      dout_q <= '0;
      vld_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          vld_q <= '0;
          if (!bus.fifo_empty && found) begin
            gnt_q <= NUM_REQ'(1) << win;
            owner <= win;
            last  <= win;
            cnt   <= '0;
            state <= SERVE;
          end
        end
        default: begin
          if (pop) begin
            dout_q <= bus.fifo_rdata;
            vld_q  <= gnt_q;
            cnt    <= cnt + CW'(1);
          end else begin
            vld_q  <= '0;
          end
          if (last_pop || !bus.req[owner]) begin
            gnt_q <= '0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.fifo_rinc = pop;
  assign bus.gnt       = gnt_q;
  assign bus.dout      = dout_q;
  assign bus.dout_vld  = vld_q;
  assign bus.busy      = (state == SERVE);
endmodule

// File: tb/tb_fifo_rd_sched.sv
// tb/tb_fifo_rd_sched.sv - randomized and directed checks of fifo_rd_sched against a reference model
module tb_fifo_rd_sched;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

  logic rclk = 1'b0;
  logic rst  = 1'b1;
  always #5 rclk = ~rclk;

  fifo_rd_sched_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_rd_sched #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .rclk (rclk),
    .rst  (rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_WIDTH-1:0] fq[$];
  logic [NUM_REQ-1:0]    dut_grants[$];
  logic [NUM_REQ-1:0]    prev_gnt = '0;

  // Reference model: owner index (-1 when nobody holds the port), pops so far in the burst.
  int                    m_owner, m_last, m_pops, m_vld;
  logic [DATA_WIDTH-1:0] m_dout;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = NUM_REQ - 1;
    m_pops  = 0;
    m_vld   = -1;
    m_dout  = '0;
  endtask

  task automatic sync_pins();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_rdata = (fq.size() != 0) ? fq[0] : '0;
  endtask

  function automatic logic [31:0] onehot(input int i);
    return (i < 0) ? 32'd0 : (32'd1 << i);
  endfunction

  task automatic cycle(input logic [NUM_REQ-1:0] rq, input logic [NUM_REQ-1:0] rd,
                       input logic r, input int npush);
    logic exp_pop;
    int   w;
    bus.req = rq;
    bus.rdy = rd;
    rst     = r;
    @(negedge rclk);
    exp_pop = !r && (m_owner >= 0) && (fq.size() != 0) && rq[m_owner] && rd[m_owner];
    expect_eq("fifo_rinc", 32'(bus.fifo_rinc), 32'(exp_pop));
    expect_eq("gnt", 32'(bus.gnt), onehot(m_owner));
    expect_eq("busy", 32'(bus.busy), 32'(m_owner >= 0));
    expect_eq("dout_vld", 32'(bus.dout_vld), onehot(m_vld));
    expect_eq("dout", 32'(bus.dout), 32'(m_dout));
    if (bus.gnt != '0 && prev_gnt == '0) dut_grants.push_back(bus.gnt);
    prev_gnt = bus.gnt;
    @(posedge rclk);
    if (r) begin
      model_reset();
    end else if (m_owner < 0) begin
      m_vld = -1;
      if (fq.size() != 0 && rq != '0) begin
        w = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
          int c;
          c = (m_last + k) % NUM_REQ;
          if (rq[c]) begin
            w = c;
            break;
          end
        end
        m_owner = w;
        m_last  = w;
        m_pops  = 0;
      end
    end else begin
      if (exp_pop) begin
        m_dout = fq[0];
        m_vld  = m_owner;
        m_pops++;
      end else begin
        m_vld = -1;
      end
      if ((exp_pop && m_pops == MAX_BURST) || !rq[m_owner]) m_owner = -1;
    end
    if (exp_pop) void'(fq.pop_front());
    for (int k = 0; k < npush; k++) fq.push_back(DATA_WIDTH'($urandom));
    #1;
    sync_pins();
  endtask

  task automatic flush();
    fq.delete();
    sync_pins();
  endtask

  initial begin
    logic [NUM_REQ-1:0] rq;
    logic [NUM_REQ-1:0] rd;
    int g0;
    bus.req = '0;
    bus.rdy = '0;
    sync_pins();
    repeat (2) @(posedge rclk);
    model_reset();
    #1;

    // Single consumer, three words, then owner keeps grant while empty.
    fq.push_back(8'hA1); fq.push_back(8'hB2); fq.push_back(8'hC3);
    sync_pins();
    cycle('0, '1, 1'b0, 0);
    repeat (8) cycle(4'b0001, 4'b1111, 1'b0, 0);
    repeat (2) cycle(4'b0000, 4'b1111, 1'b0, 0);

    // Burst limit: 10 entries pop in runs of 4,4,2.
    for (int k = 0; k < 10; k++) fq.push_back(DATA_WIDTH'($urandom));
    sync_pins();
    repeat (16) cycle(4'b0001, 4'b1111, 1'b0, 0);
    repeat (2) cycle(4'b0000, 4'b1111, 1'b0, 0);
    flush();

    // Round robin with all requesting and FIFO kept non-empty.
    cycle(4'b0000, 4'b1111, 1'b1, 0);
    for (int k = 0; k < 8; k++) fq.push_back(DATA_WIDTH'($urandom));
    sync_pins();
    g0 = dut_grants.size();
    repeat (30) cycle(4'b1111, 4'b1111, 1'b0, 1);
    for (int k = 0; k < 5; k++)
      expect_eq("rr_order", (g0 + k < dut_grants.size()) ? 32'(dut_grants[g0 + k]) : 32'hFF,
                32'd1 << (k % NUM_REQ));
    repeat (6) cycle(4'b0000, 4'b1111, 1'b0, 0);
    flush();

    // Back-pressure on the owner: rdy 1,0,0,1.
    for (int k = 0; k < 6; k++) fq.push_back(DATA_WIDTH'($urandom));
    sync_pins();
    cycle(4'b0001, 4'b1111, 1'b0, 0);
    cycle(4'b0001, 4'b0001, 1'b0, 0);
    cycle(4'b0001, 4'b0000, 1'b0, 0);
    cycle(4'b0001, 4'b0000, 1'b0, 0);
    cycle(4'b0001, 4'b0001, 1'b0, 0);
    cycle(4'b0001, 4'b0001, 1'b0, 0);
    repeat (3) cycle(4'b0000, 4'b1111, 1'b0, 0);
    flush();

    // Owner 2 withdraws after two pops; next grant wraps to consumer 0.
    cycle(4'b0000, 4'b1111, 1'b1, 0);
    for (int k = 0; k < 8; k++) fq.push_back(DATA_WIDTH'($urandom));
    sync_pins();
    cycle(4'b0100, 4'b1111, 1'b0, 0);
    repeat (2) cycle(4'b0101, 4'b1111, 1'b0, 0);
    repeat (3) cycle(4'b0001, 4'b1111, 1'b0, 0);
    expect_eq("withdraw_next", 32'(dut_grants[dut_grants.size() - 1]), 32'b0001);
    repeat (4) cycle(4'b0000, 4'b1111, 1'b0, 0);
    flush();

    // Reset during the second pop of a burst owned by consumer 1.
    for (int k = 0; k < 6; k++) fq.push_back(DATA_WIDTH'($urandom));
    sync_pins();
    cycle(4'b0010, 4'b1111, 1'b0, 0);
    cycle(4'b0010, 4'b1111, 1'b0, 0);
    cycle(4'b0010, 4'b1111, 1'b1, 0);
    repeat (3) cycle(4'b1111, 4'b1111, 1'b0, 0);
    expect_eq("rst_next_gnt", 32'(dut_grants[dut_grants.size() - 1]), 32'b0001);
    repeat (6) cycle(4'b0000, 4'b1111, 1'b0, 0);
    flush();

    // Randomized traffic, back-pressure, withdrawals and occasional resets.
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) rq = NUM_REQ'($urandom);
      rd = ($urandom_range(1) == 1) ? '1 : NUM_REQ'($urandom);
      cycle(rq, rd, ($urandom_range(199) == 0), (fq.size() < 12) ? int'($urandom_range(2)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
